// File: rtl/mmio_fifo_pkg.sv
// Shared register map, status/control bit positions and read-select encoding
// for the MMIO-mapped FIFO.
package mmio_fifo_pkg;

  localparam logic [15:0] AddrPush   = 16'h0020;
  localparam logic [15:0] AddrPop    = 16'h0022;
  localparam logic [15:0] AddrStatus = 16'h0024;
  localparam logic [15:0] AddrCtrl   = 16'h0026;
  localparam logic [15:0] AddrPeek   = 16'h0028;

  localparam int unsigned StatFullBit  = 16;
  localparam int unsigned StatEmptyBit = 17;
  localparam int unsigned StatOvfBit   = 18;
  localparam int unsigned StatUdfBit   = 19;

  localparam int unsigned CtrlFlushBit = 0;
  localparam int unsigned CtrlClrBit   = 1;

  typedef enum logic [1:0] {
    SelNone,
    SelPop,
    SelStatus,
    SelPeek
  } rd_sel_e;

  function automatic logic [31:0] pack_status(input logic [15:0] count, input logic full,
                                              input logic empty, input logic ovf,
                                              input logic udf);
    logic [31:0] w_status;
    w_status               = '0;
    w_status[15:0]         = count;
    w_status[StatFullBit]  = full;
    w_status[StatEmptyBit] = empty;
    w_status[StatOvfBit]   = ovf;
    w_status[StatUdfBit]   = udf;
    return w_status;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: DEPTH x DW, one synchronous write port and one synchronous
// read port, contents never reset.
module fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 64
) (
  input  logic                     i_clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DW-1:0]            i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DW-1:0]            o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO front end for a FIFO: push/pop/peek/status/control decode, pointers,
// occupancy, sticky error flags and a 2-stage read-response pipeline.
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mmio_wr_valid,
  input  logic                   mmio_rd_valid,
  input  logic [15:0]            mmio_addr,
  input  logic [8:0]             mmio_tid,
  input  logic [DW-1:0]          mmio_wr_data,
  output logic                   rsp_valid,
  output logic [8:0]             rsp_tid,
  output logic [DW-1:0]          rsp_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_full,
  output logic                   fifo_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          r_ovf, r_udf;

  logic          r_s1_valid;
  logic [8:0]    r_s1_tid;
  rd_sel_e       r_s1_sel;
  logic          r_s1_empty;
  logic [31:0]   r_s1_status;

  logic          w_full, w_empty, w_both;
  logic          w_push_req, w_pop_req, w_ctrl_wr, w_flush, w_clr;
  logic          w_do_push, w_do_pop, w_ovf_evt, w_udf_evt;
  rd_sel_e       w_rd_sel;
  logic [DW-1:0] w_ram_rdata, w_rsp_data;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Push and pop differ only in address bit 1; when both strobes share one
  // cycle the pair decodes as a simultaneous push and pop.
  assign w_both     = mmio_wr_valid & mmio_rd_valid;
  assign w_push_req = mmio_wr_valid & ((mmio_addr == AddrPush) | (w_both & (mmio_addr == AddrPop)));
  assign w_pop_req  = mmio_rd_valid & ((mmio_addr == AddrPop) | (w_both & (mmio_addr == AddrPush)));
  assign w_ctrl_wr  = mmio_wr_valid & (mmio_addr == AddrCtrl);
  assign w_flush    = w_ctrl_wr & mmio_wr_data[CtrlFlushBit];
  assign w_clr      = w_ctrl_wr & mmio_wr_data[CtrlClrBit];

  assign w_do_push = w_push_req & ~w_full & ~w_flush;
  assign w_do_pop  = w_pop_req & ~w_empty & ~w_flush;
  assign w_ovf_evt = w_push_req & w_full & ~w_flush;
  assign w_udf_evt = w_pop_req & w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_tail <= r_tail + AW'(1);
        if (w_do_pop)  r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
      // A new error event in the same cycle as a clear stays recorded.
      r_ovf <= (r_ovf & ~w_clr) | w_ovf_evt;
      r_udf <= (r_udf & ~w_clr) | w_udf_evt;
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_do_push),
    .i_wr_addr (r_tail),
    .i_wr_data (mmio_wr_data),
    .i_rd_en   (mmio_rd_valid),
    .i_rd_addr (r_head),
    .o_rd_data (w_ram_rdata)
  );

  always_comb begin
    w_rd_sel = SelNone;
    if (w_pop_req) begin
      w_rd_sel = SelPop;
    end else if (mmio_addr == AddrStatus) begin
      w_rd_sel = SelStatus;
    end else if (mmio_addr == AddrPeek) begin
      w_rd_sel = SelPeek;
    end
  end

  // S1: request attributes plus a snapshot of pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_tid    <= '0;
      r_s1_sel    <= SelNone;
      r_s1_empty  <= 1'b1;
      r_s1_status <= '0;
    end else begin
      r_s1_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        r_s1_tid    <= mmio_tid;
        r_s1_sel    <= w_rd_sel;
        r_s1_empty  <= w_empty;
        r_s1_status <= pack_status(16'(r_count), w_full, w_empty, r_ovf, r_udf);
      end
    end
  end

  always_comb begin
    w_rsp_data = '0;
    unique case (r_s1_sel)
      SelPop, SelPeek: w_rsp_data = r_s1_empty ? '0 : w_ram_rdata;
      SelStatus:       w_rsp_data = DW'(r_s1_status);
      default:         w_rsp_data = '0;
    endcase
  end

  // S2: registered response; data and tid hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= r_s1_valid;
      if (r_s1_valid) begin
        rsp_tid  <= r_s1_tid;
        rsp_data <= w_rsp_data;
      end
    end
  end

  assign fifo_count = r_count;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Directed self-checking bench for mmio_fifo_ctrl (DEPTH=8, DW=64).
module tb_mmio_fifo_ctrl;

  localparam logic [15:0] A_PUSH = 16'h0020;
  localparam logic [15:0] A_POP  = 16'h0022;
  localparam logic [15:0] A_STAT = 16'h0024;
  localparam logic [15:0] A_CTRL = 16'h0026;
  localparam logic [15:0] A_PEEK = 16'h0028;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wr_data = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [3:0]  fifo_count;
  logic        fifo_full, fifo_empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [63:0] exp_d[$];
  logic [8:0]  exp_t[$];
  int          req_cyc[$];

  mmio_fifo_ctrl #(
    .DEPTH (8),
    .DW    (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wr_data  (mmio_wr_data),
    .rsp_valid     (rsp_valid),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .fifo_count    (fifo_count),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_q.push_back('{rsp_tid, rsp_data, cyc});
  end

  task automatic drive(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [63:0] wdata, input logic [8:0] tid, input logic [63:0] exp);
    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_wr_data  = wdata;
    mmio_tid      = tid;
    if (rd) begin
      exp_d.push_back(exp);
      exp_t.push_back(tid);
      req_cyc.push_back(cyc);
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 64'h0, 9'h0, 64'h0);
  endtask

  task automatic push(input logic [63:0] v);
    drive(1'b1, 1'b0, A_PUSH, v, 9'h0, 64'h0);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [8:0] tid, input logic [63:0] exp);
    drive(1'b0, 1'b1, addr, 64'h0, tid, exp);
  endtask

  task automatic clear_q();
    rsp_q.delete();
    exp_d.delete();
    exp_t.delete();
    req_cyc.delete();
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) idle();
    checks += 2;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL post_reset_count got %0d want 0", fifo_count); end
    if (rsp_data !== 64'h0) begin errors++; $display("FAIL post_reset_rsp_data got %h want 0", rsp_data); end
  endtask

  task automatic test_basic();
    clear_q();
    push(64'hA1); push(64'hA2); push(64'hA3);
    idle();
    checks++;
    if (fifo_count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d want 3", fifo_count); end
    rd(A_POP, 9'd1, 64'hA1); rd(A_POP, 9'd2, 64'hA2); rd(A_POP, 9'd3, 64'hA3);
    rd(A_STAT, 9'd4, 64'h2_0000);
    repeat (4) idle();
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL basic_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 3;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL basic_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
      if (rsp_q[j].cyc - req_cyc[j] != 2) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 2", j, rsp_q[j].cyc - req_cyc[j]); end
    end
    checks++;
    if (rsp_data !== 64'h2_0000) begin errors++; $display("FAIL basic_hold got %h want 20000", rsp_data); end
  endtask

  task automatic test_overflow();
    clear_q();
    for (int i = 1; i <= 9; i++) push(64'(i));
    idle();
    checks += 3;
    if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", fifo_count); end
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    if (fifo_empty !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", fifo_empty); end
    rd(A_STAT, 9'h0F, 64'h5_0008);
    for (int i = 1; i <= 8; i++) rd(A_POP, 9'(16 + i), 64'(i));
    rd(A_STAT, 9'h1F, 64'h6_0000);
    repeat (4) idle();
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL ovf_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 2;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL ovf_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
    end
  endtask

  task automatic test_underflow();
    clear_q();
    rd(A_POP, 9'h1AA, 64'h0);
    rd(A_STAT, 9'h1AB, 64'hE_0000);
    drive(1'b1, 1'b0, A_CTRL, 64'hFFFF_FFF0_0000_0002, 9'h0, 64'h0);
    rd(A_STAT, 9'h1AC, 64'h2_0000);
    rd(16'h0030, 9'h1AD, 64'h0);
    repeat (4) idle();
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL udf_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 3;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL udf_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL udf_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
      if (rsp_q[j].cyc - req_cyc[j] != 2) begin errors++; $display("FAIL udf_latency[%0d] got %0d want 2", j, rsp_q[j].cyc - req_cyc[j]); end
    end
  endtask

  task automatic test_same_cycle();
    clear_q();
    push(64'h11); push(64'h22); push(64'h33);
    drive(1'b1, 1'b1, A_POP, 64'h55, 9'h20, 64'h11);
    idle();
    checks++;
    if (fifo_count !== 4'd3) begin errors++; $display("FAIL simul_count got %0d want 3", fifo_count); end
    rd(A_POP, 9'h21, 64'h22); rd(A_POP, 9'h22, 64'h33); rd(A_POP, 9'h23, 64'h55);
    // Empty FIFO: push only, pop underflows; the next pop sees the pushed entry.
    drive(1'b1, 1'b1, A_POP, 64'h66, 9'h24, 64'h0);
    rd(A_POP, 9'h25, 64'h66);
    rd(A_STAT, 9'h26, 64'hA_0000);
    push(64'h77); push(64'h78);
    drive(1'b1, 1'b0, A_CTRL, 64'h3, 9'h0, 64'h0);
    idle();
    checks += 2;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", fifo_count); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b want 1", fifo_empty); end
    rd(A_STAT, 9'h27, 64'h2_0000);
    repeat (4) idle();
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL simul_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 2;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL simul_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL simul_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] model[$];
    logic [8:0]  tid;
    clear_q();
    tid = 9'h40;
    for (int i = 0; i < 20; i++) begin
      push(64'h100 + 64'(i));
      model.push_back(64'h100 + 64'(i));
      if (i >= 2) begin
        rd(A_PEEK, tid, model[0]); tid++;
        rd(A_POP, tid, model.pop_front()); tid++;
      end
    end
    idle();
    rd(A_PEEK, tid, model[0]); tid++;
    idle();
    checks++;
    if (fifo_count !== 4'd2) begin errors++; $display("FAIL peek_count got %0d want 2", fifo_count); end
    while (model.size() > 0) begin
      rd(A_POP, tid, model.pop_front()); tid++;
    end
    repeat (4) idle();
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", fifo_count); end
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL wrap_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 2;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL wrap_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
    end
  endtask

  task automatic test_reset_mid_read();
    clear_q();
    push(64'h41); push(64'h42); push(64'h43); push(64'h44);
    idle();
    checks++;
    if (fifo_count !== 4'd4) begin errors++; $display("FAIL midrst_pre_count got %0d want 4", fifo_count); end
    rd(A_POP, 9'h33, 64'h41);
    @(posedge clk);
    #2;
    rst = 1'b1;
    mmio_rd_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL midrst_async_count got %0d want 0", fifo_count); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_q();
    repeat (4) idle();
    checks += 3;
    if (rsp_q.size() != 0) begin errors++; $display("FAIL midrst_rsp got %0d want 0", rsp_q.size()); end
    if (fifo_count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
    if (fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b want 1", fifo_empty); end
    clear_q();
    rd(A_POP, 9'h34, 64'h0);
    rd(A_STAT, 9'h35, 64'hA_0000);
    repeat (4) idle();
    checks++;
    if (rsp_q.size() != exp_d.size()) begin
      errors++; $display("FAIL midrst_nrsp got %0d want %0d", rsp_q.size(), exp_d.size());
    end
    for (int j = 0; j < exp_d.size() && j < rsp_q.size(); j++) begin
      checks += 2;
      if (rsp_q[j].data !== exp_d[j]) begin errors++; $display("FAIL midrst_data[%0d] got %h want %h", j, rsp_q[j].data, exp_d[j]); end
      if (rsp_q[j].tid !== exp_t[j]) begin errors++; $display("FAIL midrst_tid[%0d] got %h want %h", j, rsp_q[j].tid, exp_t[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_same_cycle();
    test_wrap();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_ctrl.md
MMIO_FIFO_CTRL -- requirements
Module: mmio_fifo_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; SHALL be a power of 2, 2..256.
REQ-002 SHALL have parameter DW, default 64, data width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 mmio_wr_valid  in  1  MMIO write strobe, one cycle per write.
REQ-006 mmio_rd_valid  in  1  MMIO read strobe, one cycle per read.
REQ-007 mmio_addr  in  16  MMIO dword address, shared by read and write.
REQ-008 mmio_tid  in  9  read transaction ID.
REQ-009 mmio_wr_data  in  DW  write payload.
REQ-010 rsp_valid  out  1  read-response strobe, one cycle per response.
REQ-011 rsp_tid  out  9  TID echoed from the matching read.
REQ-012 rsp_data  out  DW  read-response data.
REQ-013 fifo_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 fifo_full / fifo_empty  out  1 each  combinational decode of fifo_count.

Function
REQ-015 Address map SHALL be: 0x0020 W push; 0x0022 R pop; 0x0024 R status; 0x0026 W control; 0x0028 R peek (head without pop).
REQ-016 Status word SHALL be {count in [15:0], full [16], empty [17], overflow sticky [18], underflow sticky [19], zeros above}.
REQ-017 A control write SHALL act on bit0 = flush (head, tail and count go to 0) and bit1 = clear both stickies; other bits SHALL be ignored.
REQ-018 A write to 0x0020 when not full SHALL store data at tail; tail and count SHALL update at the next posedge.
REQ-019 A write to 0x0020 when full SHALL drop the data, leave state unchanged and set overflow.
REQ-020 A read of 0x0022 when not empty SHALL return the head entry; head SHALL advance and count SHALL decrement at the next posedge.
REQ-021 A read of 0x0022 when empty SHALL return 0 and set underflow; head and count SHALL be unchanged.
REQ-022 Full, empty and sticky evaluation SHALL use the pre-edge count.
  - Push and pop in the same cycle with 0<count<DEPTH: both take effect, count unchanged.
  - Push and pop in the same cycle with count==0: push only, and the pop takes underflow.
  - Push and pop in the same cycle with count==DEPTH: pop only, and the push takes overflow.
REQ-023 Flush and push in the same cycle: flush SHALL win and the push data SHALL be discarded, with no overflow.
REQ-024 Head and tail pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-025 Read path SHALL be a 2-stage pipeline.
  - Stage S1 captures valid, tid and address select, and issues the RAM read at head.
  - Stage S2 drives rsp_*.
  - rsp_valid SHALL assert exactly 2 cycles after mmio_rd_valid.
REQ-026 Back-to-back reads SHALL be accepted every cycle, with no stall and no dropped response, and responses SHALL be in request order.
REQ-027 Consecutive pops in adjacent cycles SHALL return consecutive entries.
REQ-028 A pop in the cycle after a push into an empty FIFO SHALL return the pushed data (write-to-read bypass where RAM timing requires it).
REQ-029 Status and peek SHALL reflect state at the request cycle, excluding any same-cycle push or pop.
REQ-030 Reads of unmapped addresses SHALL return 0 with normal latency; writes to unmapped or read-only addresses SHALL be ignored.
REQ-031 rsp_data SHALL hold its last value when rsp_valid is low.

Reset
REQ-032 On rst, the following SHALL clear immediately and asynchronously: head, tail, count, both stickies, both pipeline valids, rsp_valid, rsp_tid, rsp_data.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 A read in flight at reset SHALL produce no response.
REQ-035 Outputs after reset SHALL be fifo_empty=1, fifo_full=0, fifo_count=0.

Structure
REQ-036 Register addresses, status bit positions and control bit positions SHALL live in shared package mmio_fifo_pkg.
REQ-037 Storage SHALL be sub-module fifo_ram: DEPTH x DW, one synchronous write port and one synchronous read port, no reset.
REQ-038 The controller SHALL own the pointers, count, stickies and response pipeline.

Verification
REQ-039 Reset, then push 0xA1, 0xA2, 0xA3, then three back-to-back pops -> responses A1, A2, A3 at +2 cycles each with tids echoed, then status shows empty=1, count=0.
REQ-040 Push 9 values with DEPTH=8 -> count=8, full=1, overflow=1; 9th value absent; 8 pops return values 1..8 in order.
REQ-041 Pop when empty -> rsp_data=0 and underflow=1; then control write 0x2 -> status underflow=0, overflow=0.
REQ-042 count=3, same-cycle push 0x55 and pop -> pop returns old head, count stays 3; later pops end with 0x55.
REQ-043 Push 20 values through with interleaved pops (pointer wrap) -> FIFO order preserved; peek equals next pop value and does not change count.
REQ-044 rst asserted mid-read while count=4 -> no rsp_valid; after release count=0, empty=1, a pop returns 0.
